candidate_bank_reader: RTL and testbench

Sequential read-side engine for the 16-byte candidate memory bank. On a start request it walks the bank from byte address 0 in 2-byte steps. For each entry it fetches a big-endian 16-bit word and presents it on a valid/ready stream to the downstream routing logic. A `done` pulse marks the end of each sweep. An optional compiled-in tracker reports the largest candidate word seen during the sweep and its position.

---
 rtl/candidate_bank_reader_if.sv | 21 ++
 rtl/candidate_bank_reader.sv | 116 +++++++++++
 tb/tb_candidate_bank_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/candidate_bank_reader_if.sv
// Bank read port plus candidate output stream between the reader (master) and its consumers (slave).
interface candidate_bank_reader_if #(
  parameter int WORD_WIDTH = 16
);
  logic [15:0]           mem_index;
  logic [WORD_WIDTH-1:0] mem_rd_data;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_index, out_data, out_valid, out_last,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_index, out_data, out_valid, out_last,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/candidate_bank_reader.sv
// Sweeps the candidate bank in 2-byte steps and streams big-endian words downstream.
// Optional argmax tracker enabled by defining CAND_ARGMAX_EN.
module candidate_bank_reader #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [3:0]            count,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            best_index,
  output logic [WORD_WIDTH-1:0] best_value,
  candidate_bank_reader_if.master bus
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | capture bank word into out_data
  // SEND  | hold word until downstream accepts it
  // DONE  | one-cycle end-of-sweep pulse
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [3:0] MAX_WORDS = 4'(MEM_DEPTH / 2);

  state_t     state, state_next;
  logic [3:0] eff;
  logic [2:0] word_cnt;
  logic       load, fetch, hs;

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    fetch      = 1'b0;
    hs         = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (count == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        fetch      = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (bus.out_valid && bus.out_ready) begin
          hs         = 1'b1;
          state_next = bus.out_last ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      eff           <= '0;
      word_cnt      <= '0;
      bus.mem_index <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      if (load) begin
        eff           <= (count > MAX_WORDS) ? MAX_WORDS : count;
        word_cnt      <= '0;
        bus.mem_index <= '0;
      end
      if (fetch) begin
        bus.out_data  <= bus.mem_rd_data;
        bus.out_valid <= 1'b1;
        bus.out_last  <= ({1'b0, word_cnt} == eff - 4'd1);
      end
      if (hs) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
        // Index only advances when another word follows, so it never passes the last entry.
        if (!bus.out_last) begin
          word_cnt      <= word_cnt + 3'd1;
          bus.mem_index <= bus.mem_index + 16'd2;
        end
      end
    end
  end

`ifdef CAND_ARGMAX_EN
  always_ff @(posedge clk) begin
    if (!nrst || load) begin
      best_index <= '0;
      best_value <= '0;
    end else if (hs && (bus.out_data > best_value)) begin
      // Strict compare keeps the earliest index on ties.
      best_index <= word_cnt;
      best_value <= bus.out_data;
    end
  end
`else
  assign best_index = '0;
  assign best_value = '0;
`endif

endmodule

// File: tb/tb_candidate_bank_reader.sv
// Self-checking bench for candidate_bank_reader: vector table, corner sequences, random sweeps vs a bank model.
module tb_candidate_bank_reader;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  count = 4'd0;
  logic        busy, done;
  logic [2:0]  best_index;
  logic [15:0] best_value;
  logic [7:0]  bank [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    int mode;
    int exp_words;
  } vec_t;
  vec_t vecs [8];

  candidate_bank_reader_if #(.WORD_WIDTH(16)) bus();

  assign bus.mem_rd_data = {bank[bus.mem_index[3:0]], bank[bus.mem_index[3:0] + 4'd1]};

  candidate_bank_reader #(.WORD_WIDTH(16), .MEM_DEPTH(16)) dut (
    .clk(clk), .nrst(nrst), .start(start), .count(count), .busy(busy), .done(done),
    .best_index(best_index), .best_value(best_value), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int k);
    return {bank[2*k], bank[2*k+1]};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_index"}, bus.mem_index, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_best_idx"}, best_index, 0);
    chk({tag, "_best_val"}, best_value, 0);
  endtask

  // Called just after a negedge. mode: 0 ready high, 1 ready 0,0,1 per word, 2 random ready.
  task automatic run_sweep(input int cnt, input int mode, input int eff);
    int k, cyc, last_hs, wcnt;
    logic r, hs_pend, prev_valid, finished, seen_valid;
    logic [15:0] bv;
    int bi;
    bv = 16'd0;
    bi = 0;
    for (int i = 0; i < eff; i++)
      if (model_word(i) > bv) begin bv = model_word(i); bi = i; end
    start = 1'b1;
    count = cnt[3:0];
    @(negedge clk);
    start = 1'b0;
    cyc = 1; k = 0; last_hs = 0; wcnt = 0;
    hs_pend = 1'b0; prev_valid = 1'b0; finished = 1'b0; seen_valid = 1'b0;
    while (!finished && cyc < 300) begin
      if (hs_pend) begin k++; wcnt = 0; end
      if (prev_valid && !hs_pend) chk("held_valid", bus.out_valid, 1);
      chk("busy", busy, 1);
      chk("index_range", (bus.mem_index <= 16'd14) && !bus.mem_index[0], 1);
      if (done) begin
        chk("done_words", k, eff);
        chk("done_latency", cyc, (eff == 0) ? 1 : last_hs + 1);
        if (mode == 0) chk("sweep_cycles", cyc, 2*eff + 1);
        chk("valid_at_done", bus.out_valid, 0);
`ifdef CAND_ARGMAX_EN
        chk("best_value", best_value, bv);
        chk("best_index", best_index, bi);
`else
        chk("best_value", best_value, 0);
        chk("best_index", best_index, 0);
`endif
        finished = 1'b1;
      end else if (bus.out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          chk("first_valid_latency", cyc, 2);
        end
        if (k < eff) begin
          chk("out_data", bus.out_data, model_word(k));
          chk("out_last", bus.out_last, (k == eff - 1));
          chk("mem_index", bus.mem_index, 2*k);
        end else begin
          chk("extra_word", k, eff - 1);
        end
        wcnt++;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (wcnt >= 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      prev_valid = bus.out_valid && !finished;
      hs_pend = bus.out_valid && r && !finished;
      if (hs_pend) last_hs = cyc;
      @(negedge clk);
      cyc++;
    end
    if (!finished) chk("sweep_timeout", 0, 1);
    chk("busy_after_done", busy, 0);
    chk("done_pulse_width", done, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    vecs[0] = '{cnt: 8,  mode: 0, exp_words: 8};
    vecs[1] = '{cnt: 3,  mode: 1, exp_words: 3};
    vecs[2] = '{cnt: 0,  mode: 0, exp_words: 0};
    vecs[3] = '{cnt: 12, mode: 0, exp_words: 8};
    vecs[4] = '{cnt: 15, mode: 1, exp_words: 8};
    vecs[5] = '{cnt: 1,  mode: 0, exp_words: 1};
    vecs[6] = '{cnt: 5,  mode: 2, exp_words: 5};
    vecs[7] = '{cnt: 9,  mode: 2, exp_words: 8};
    for (int i = 0; i < 16; i++) bank[i] = 8'(i);

    // Reset held with start asserted
    start = 1'b1;
    nrst  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    start = 1'b0;
    nrst  = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 8; v++)
      run_sweep(vecs[v].cnt, vecs[v].mode, vecs[v].exp_words);

    // Abort during the second word's SEND, then a clean two-word sweep
    begin
      int n;
      logic hit;
      hit = 1'b0;
      start = 1'b1;
      count = 4'd3;
      bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 0; n < 20 && !hit; n++) begin
        if (bus.out_valid && bus.out_data == 16'h0203) hit = 1'b1;
        else @(negedge clk);
      end
      chk("abort_reached_word1", hit, 1);
      bus.out_ready = 1'b0;
      nrst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("abort");
      nrst = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
      end
      run_sweep(2, 0, 2);
    end

    // Start held high: back-to-back sweeps with one idle cycle between
    begin
      int d;
      start = 1'b1;
      count = 4'd1;
      bus.out_ready = 1'b1;
      d = -1;
      for (int c = 1; c < 20 && d < 0; c++) begin
        @(negedge clk);
        if (done) d = c;
      end
      chk("held_start_done_seen", (d > 0), 1);
      chk("held_start_done_cycle", d, 3);
      @(negedge clk);
      chk("held_start_idle_gap", busy, 0);
      @(negedge clk);
      chk("held_start_restart", busy, 1);
      start = 1'b0;
      for (int c = 0; c < 20 && busy; c++) @(negedge clk);
      chk("held_start_drained", busy, 0);
      bus.out_ready = 1'b0;
    end

    // Argmax with a tie at the maximum
    for (int i = 0; i < 16; i++) bank[i] = 8'($urandom);
    bank[0] = 8'h00; bank[1] = 8'h10;
    bank[2] = 8'h80; bank[3] = 8'h00;
    bank[4] = 8'h80; bank[5] = 8'h00;
    bank[6] = 8'h00; bank[7] = 8'h01;
    run_sweep(4, 0, 4);
`ifdef CAND_ARGMAX_EN
    chk("argmax_value", best_value, 16'h8000);
    chk("argmax_index", best_index, 3'd1);
`else
    chk("argmax_value_off", best_value, 16'h0000);
    chk("argmax_index_off", best_index, 3'd0);
`endif

    // Randomized sweeps against the bank model
    for (int t = 0; t < 40; t++) begin
      int c;
      for (int i = 0; i < 16; i++) bank[i] = 8'($urandom);
      c = $urandom_range(0, 15);
      run_sweep(c, (t % 4 == 0) ? 1 : 2, (c > 8) ? 8 : c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
